// File: rtl/lcd_bus_target.sv
// Panel-side target of an 8080-style parallel LCD bus.
// Host strobes are synchronised into i_clk. Each completed write is captured
// as an {rs,data} word into a small FIFO, which drains over a valid/ready stream.
// A host read raises a one-cycle request and then drives back i_rdata.
module lcd_bus_target #(
   parameter int DW          = 24,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_cs,
   input  logic          i_rs,
   input  logic          i_wr,
   input  logic          i_rd,
   input  logic          i_lcd_rst,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_data_oe,
   output logic [DW-1:0] o_word,
   output logic          o_word_rs,
   output logic          o_word_valid,
   input  logic          i_word_ready,
   output logic          o_rd_req,
   output logic          o_word_rs_rd,
   input  logic [DW-1:0] i_rdata,
   output logic          o_lcd_rst,
   output logic          o_overflow,
   input  logic          i_clr_ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {W_IDLE, W_ACT} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DRV} rstate_e;

   logic [SYNC_STAGES-1:0]         cs_sync_q, rs_sync_q, wr_sync_q, rd_sync_q, lrst_sync_q;
   logic [SYNC_STAGES-1:0][DW-1:0] data_sync_q;
   logic                           wr_prev_q;
   logic                           cs_s, rs_s, wr_s, rd_s, lrst_s, wr_rise;
   logic [DW-1:0]                  data_s;

   wstate_e                        w_state_q;
   rstate_e                        r_state_q;
   logic                           rd_req_q, rs_rd_q, oe_q;
   logic [DW-1:0]                  rdata_q;

   logic [FIFO_DEPTH-1:0][DW:0]    mem_q;
   logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                  count_q, count_d;
   logic                           ovf_q, ovf_d;
   logic                           push, pop, full, push_ok;

   // Synchronise every bus input; the data bus shares the same depth so it stays aligned with WR.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cs_sync_q   <= '1;
         rs_sync_q   <= '0;
         wr_sync_q   <= '1;
         rd_sync_q   <= '1;
         lrst_sync_q <= '1;
         data_sync_q <= '0;
         wr_prev_q   <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs};
         rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], i_rs};
         wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], i_wr};
         rd_sync_q   <= {rd_sync_q[SYNC_STAGES-2:0], i_rd};
         lrst_sync_q <= {lrst_sync_q[SYNC_STAGES-2:0], i_lcd_rst};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i_data};
         wr_prev_q   <= wr_s;
      end
   end

   assign cs_s    = cs_sync_q[SYNC_STAGES-1];
   assign rs_s    = rs_sync_q[SYNC_STAGES-1];
   assign wr_s    = wr_sync_q[SYNC_STAGES-1];
   assign rd_s    = rd_sync_q[SYNC_STAGES-1];
   assign lrst_s  = lrst_sync_q[SYNC_STAGES-1];
   assign data_s  = data_sync_q[SYNC_STAGES-1];
   assign wr_rise = wr_s & ~wr_prev_q;

   // A write completes on the WR rising edge while still selected; panel reset blocks it.
   assign push = (w_state_q == W_ACT) & wr_rise & ~cs_s & lrst_s;
   assign pop  = o_word_valid & i_word_ready & lrst_s;

   // Write FSM: WR and RD low together keeps both FSMs idle until one strobe releases.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         w_state_q <= W_IDLE;
      end else if (!lrst_s) begin
         w_state_q <= W_IDLE;
      end else begin
         case (w_state_q)
            W_IDLE: if (!cs_s && !wr_s && rd_s && r_state_q == R_IDLE) w_state_q <= W_ACT;
            W_ACT:  if (wr_rise || cs_s) w_state_q <= W_IDLE;
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Read FSM with registered request pulse, drive enable and read data.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state_q <= R_IDLE;
         rd_req_q  <= 1'b0;
         rs_rd_q   <= 1'b0;
         oe_q      <= 1'b0;
         rdata_q   <= '0;
      end else if (!lrst_s) begin
         r_state_q <= R_IDLE;
         rd_req_q  <= 1'b0;
         oe_q      <= 1'b0;
      end else begin
         rd_req_q <= 1'b0;
         case (r_state_q)
            R_IDLE: begin
               if (!cs_s && !rd_s && wr_s && w_state_q == W_IDLE) begin
                  r_state_q <= R_REQ;
                  rd_req_q  <= 1'b1;
                  rs_rd_q   <= rs_s;
               end
            end
            R_REQ: begin
               // i_rdata is taken one clock after the request pulse.
               r_state_q <= R_DRV;
               rdata_q   <= i_rdata;
               oe_q      <= 1'b1;
            end
            R_DRV: begin
               if (rd_s || cs_s) begin
                  r_state_q <= R_IDLE;
                  oe_q      <= 1'b0;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // FIFO next state: a pop frees the slot for a same-cycle push when full; panel reset flushes.
   always_comb begin
      full     = (count_q == CW'(FIFO_DEPTH));
      push_ok  = push & (~full | pop);
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push_ok) - CW'(pop);
      ovf_d    = (push & full & ~pop) | (ovf_q & ~i_clr_ovf);
      if (!lrst_s) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // FIFO storage, pointers and the sticky overflow flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) mem_q[wr_ptr_q] <= {rs_s, data_s};
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   assign o_word       = mem_q[rd_ptr_q][DW-1:0];
   assign o_word_rs    = mem_q[rd_ptr_q][DW];
   assign o_word_valid = |count_q;
   assign o_overflow   = ovf_q;
   assign o_lcd_rst    = ~lrst_s;
   assign o_rd_req     = rd_req_q;
   assign o_word_rs_rd = rs_rd_q;
   assign o_data_oe    = oe_q;
   assign o_data       = rdata_q;

endmodule

// File: tb/tb_lcd_bus_target.sv
// Bench for lcd_bus_target: directed bus transactions feed a timestamped
// queue model; a per-cycle compare checks every output against it.
module tb_lcd_bus_target;
   localparam int BIG = 1 << 30;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cs = 1'b1, rs = 1'b0, wr = 1'b1, rd = 1'b1, lcd_rst = 1'b1;
   logic [23:0] data = '0, rdata = '0;
   logic        ready = 1'b0, clr = 1'b0;
   logic [23:0] o_data, o_word;
   logic        o_data_oe, o_word_rs, o_word_valid, o_rd_req, o_word_rs_rd, o_lcd_rst, o_overflow;

   lcd_bus_target #(.DW(24), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_rs(rs), .i_wr(wr), .i_rd(rd),
      .i_lcd_rst(lcd_rst), .i_data(data), .o_data(o_data), .o_data_oe(o_data_oe),
      .o_word(o_word), .o_word_rs(o_word_rs), .o_word_valid(o_word_valid),
      .i_word_ready(ready), .o_rd_req(o_rd_req), .o_word_rs_rd(o_word_rs_rd),
      .i_rdata(rdata), .o_lcd_rst(o_lcd_rst), .o_overflow(o_overflow), .i_clr_ovf(clr)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [24:0] w;} push_t;

   int          checks = 0, failures = 0;
   int          cyc = 0;
   bit          model_en = 1'b0;
   push_t       sched[$];
   logic [24:0] mq[$];
   logic [24:0] popped[$];
   logic        m_ovf = 1'b0;
   int          fl_from = -1, fl_to = -2, prst_from = -1, prst_to = -2;
   int          m_rdreq_cyc = -1, m_oe_from = -1, m_oe_to = -2;
   logic        m_rdrs = 1'b0;
   logic [23:0] m_rdata = '0;
   int          rdreq_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Model: cycle count, scheduled pushes landing on their edge, pops, flush, overflow.
   initial forever begin
      logic        in_fl, do_pop, do_push, set;
      logic [24:0] w;
      @(posedge clk);
      cyc++;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         in_fl   = (cyc >= fl_from && cyc <= fl_to);
         do_pop  = (mq.size() != 0) && ready && !in_fl;
         do_push = 1'b0;
         w       = '0;
         if (sched.size() != 0 && sched[0].cyc == cyc) begin
            w       = sched[0].w;
            do_push = !in_fl;
            void'(sched.pop_front());
         end
         set = do_push && mq.size() == 4 && !do_pop;
         if (do_pop) void'(mq.pop_front());
         if (do_push && !set) mq.push_back(w);
         if (in_fl) mq.delete();
         m_ovf = set || (m_ovf && !clr);
      end
   end

   // Compare every cycle, away from the active edge.
   initial forever begin
      logic oe_exp;
      @(negedge clk);
      #2;
      if (model_en && !rst) begin
         chk("valid", o_word_valid, mq.size() != 0);
         if (mq.size() != 0) chk("word", {o_word_rs, o_word}, mq[0]);
         chk("ovf", o_overflow, m_ovf);
         chk("lcd_rst", o_lcd_rst, cyc >= prst_from && cyc <= prst_to);
         chk("rd_req", o_rd_req, cyc == m_rdreq_cyc);
         if (cyc == m_rdreq_cyc) chk("rs_rd", o_word_rs_rd, m_rdrs);
         oe_exp = (cyc >= m_oe_from && cyc <= m_oe_to);
         chk("oe", o_data_oe, oe_exp);
         if (oe_exp) chk("rdata", o_data, m_rdata);
      end
      if (o_word_valid && ready) popped.push_back({o_word_rs, o_word});
      if (o_rd_req) rdreq_cnt++;
   end

   task automatic wr_tx(input logic rs_v, input logic [23:0] d, input bit lat, input bit pop_at);
      int c;
      @(negedge clk);
      cs = 1'b0; rs = rs_v; data = d; wr = 1'b0;
      repeat (4) @(negedge clk);
      wr = 1'b1;
      c  = cyc;
      sched.push_back('{c + 3, {rs_v, d}});
      repeat (2) @(negedge clk);
      if (lat) chk("wr_lat_pre", o_word_valid, 0);
      if (pop_at) ready = 1'b1;
      @(negedge clk);
      if (lat) chk("wr_lat_post", o_word_valid, 1);
      if (pop_at) ready = 1'b0;
      cs = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic rd_tx(input logic rs_v, input logic [23:0] rv);
      int c, r, n0;
      @(negedge clk);
      cs = 1'b0; rs = rs_v; rd = 1'b0; rdata = rv;
      c = cyc; n0 = rdreq_cnt;
      m_rdreq_cyc = c + 3; m_rdrs = rs_v; m_oe_from = c + 4; m_oe_to = BIG; m_rdata = rv;
      repeat (3) @(negedge clk);
      chk("rd_req_lit", o_rd_req, 1);
      chk("rd_rs_lit", o_word_rs_rd, rs_v);
      @(negedge clk);
      chk("rd_oe_lit", o_data_oe, 1);
      chk("rd_data_lit", o_data, rv);
      repeat (2) @(negedge clk);
      rd = 1'b1;
      r = cyc;
      m_oe_to = r + 2;
      repeat (3) @(negedge clk);
      chk("rd_oe_off", o_data_oe, 0);
      chk("rd_pulses", rdreq_cnt - n0, 1);
      cs = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic drain(input int exp_n);
      popped.delete();
      @(negedge clk);
      ready = 1'b1;
      for (int i = 0; i < 20 && (o_word_valid || i < 2); i++) @(negedge clk);
      ready = 1'b0;
      chk("drain_empty", o_word_valid, 0);
      chk("drain_count", popped.size(), exp_n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (3) @(negedge clk);
      chk("rst_data", o_data, 0);
      chk("rst_oe", o_data_oe, 0);
      chk("rst_word", {o_word_rs, o_word}, 0);
      chk("rst_valid", o_word_valid, 0);
      chk("rst_rdreq", {o_rd_req, o_word_rs_rd}, 0);
      chk("rst_lcd", o_lcd_rst, 0);
      chk("rst_ovf", o_overflow, 0);
      rst = 1'b0;
      model_en = 1'b1;
      repeat (2) @(negedge clk);

      // Single command write.
      wr_tx(1'b0, 24'h00002C, 1'b1, 1'b0);
      chk("cmd_word", {o_word_rs, o_word}, 25'h000002C);
      drain(1);

      // Five data writes into a depth-4 FIFO.
      for (int i = 1; i <= 5; i++) wr_tx(1'b1, 24'(i), 1'b0, 1'b0);
      chk("ovf_set", o_overflow, 1);
      chk("ovf_head", {o_word_rs, o_word}, 25'h1000001);
      drain(4);
      for (int i = 0; i < 4; i++) chk("ovf_order", popped[i], {1'b1, 24'(i + 1)});

      // Host read.
      rd_tx(1'b1, 24'hABCDEF);

      // Aborted write, then a normal one.
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; data = 24'h0000EE;
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (3) @(negedge clk);
      wr = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_none", o_word_valid, 0);
      wr_tx(1'b0, 24'h000077, 1'b1, 1'b0);
      chk("abort_next", {o_word_rs, o_word}, 25'h0000077);
      drain(1);

      // Panel reset with three words queued; overflow stays set.
      for (int i = 0; i < 3; i++) wr_tx(1'b0, 24'h10 + 24'(i), 1'b0, 1'b0);
      @(negedge clk);
      lcd_rst = 1'b0;
      c = cyc;
      prst_from = c + 2; prst_to = BIG; fl_from = c + 3; fl_to = BIG;
      repeat (4) @(negedge clk);
      chk("prst_valid", o_word_valid, 0);
      chk("prst_out", o_lcd_rst, 1);
      chk("prst_ovf", o_overflow, 1);
      wr_tx(1'b1, 24'h000099, 1'b0, 1'b0);
      chk("prst_ignored", o_word_valid, 0);
      lcd_rst = 1'b1;
      c = cyc;
      prst_to = c + 1; fl_to = c + 2;
      repeat (4) @(negedge clk);
      chk("prst_off", o_lcd_rst, 0);
      wr_tx(1'b0, 24'h000055, 1'b1, 1'b0);
      chk("prst_after", {o_word_rs, o_word}, 25'h0000055);
      drain(1);

      // Clear overflow, then push and pop together while full.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("ovf_clr", o_overflow, 0);
      for (int i = 1; i <= 4; i++) wr_tx(1'b1, 24'h20 + 24'(i), 1'b0, 1'b0);
      wr_tx(1'b1, 24'h000025, 1'b0, 1'b1);
      chk("full_pp_ovf", o_overflow, 0);
      chk("full_pp_head", {o_word_rs, o_word}, 25'h1000022);
      drain(4);
      chk("full_pp_last", popped[3], 25'h1000025);

      // Reset asserted mid-read.
      @(negedge clk);
      cs = 1'b0; rs = 1'b0; rd = 1'b0; rdata = 24'h123456;
      c = cyc;
      m_rdreq_cyc = c + 3; m_rdrs = 1'b0; m_oe_from = c + 4; m_oe_to = BIG; m_rdata = 24'h123456;
      repeat (5) @(negedge clk);
      chk("mid_oe", o_data_oe, 1);
      model_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_oe", o_data_oe, 0);
      chk("mid_rst_data", o_data, 0);
      chk("mid_rst_req", o_rd_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
